// File: rtl/inc16_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit incrementer among NREQ requesters.
// One-cycle latency into a single result slot; a full slot not being drained blocks all grants.
module inc16_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [IDW-1:0]        rsp_id,
   output logic                  rsp_ovf,
   output logic                  busy
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

   slot_state_t      state;
   slot_state_t      state_nxt;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   grant_idx;
   logic [IDW-1:0]   wrap_idx;
   logic             grant_found;
   logic             wrap_found;
   logic             slot_free;
   logic             accept;
   logic [WIDTH-1:0] sel_data;

   // Descending scan: the last hit is the lowest index, so grant_idx ends up as the
   // first valid at or after ptr, and wrap_idx as the first valid overall.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      wrap_found  = 1'b0;
      wrap_idx    = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (req_valid[j]) begin
            wrap_found = 1'b1;
            wrap_idx   = IDW'(j);
            if (IDW'(j) >= ptr) begin
               grant_found = 1'b1;
               grant_idx   = IDW'(j);
            end
         end
      end
      if (!grant_found) begin
         grant_found = wrap_found;
         grant_idx   = wrap_idx;
      end
   end

   assign slot_free = (state == EMPTY) || rsp_ready;
   assign accept    = grant_found && slot_free;

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      sel_data = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (IDW'(j) == grant_idx) begin
            sel_data = req_data[j*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (accept) state_nxt = FULL;
         FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_comb begin
      rsp_valid = (state == FULL);
      busy      = (state == FULL);
   end

   // Result fields only move on a new accept, so a pop leaves the last values visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data <= '0;
         rsp_id   <= '0;
         rsp_ovf  <= 1'b0;
         ptr      <= '0;
      end else if (accept) begin
         rsp_data <= sel_data + WIDTH'(1);
         rsp_ovf  <= &sel_data;
         rsp_id   <= grant_idx;
         ptr      <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
   end

endmodule

// File: tb/tb_inc16_arbiter.sv
// Directed and random stimulus for inc16_arbiter with a reference arbiter model and result scoreboard.
module tb_inc16_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 16;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [WIDTH-1:0]      rsp_data;
   logic [IDW-1:0]        rsp_id;
   logic                  rsp_ovf;
   logic                  busy;

   inc16_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ovf   (rsp_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IDW-1:0]   id;
      logic [WIDTH-1:0] dat;
      logic             ovf;
   } exp_t;

   exp_t            sbq[$];
   int              vectors     = 0;
   int              miscompares = 0;
   logic            m_full;
   int              mptr;
   logic [NREQ-1:0] last_acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic set_data(input int i, input logic [WIDTH-1:0] v);
      req_data[i*WIDTH +: WIDTH] = v;
   endtask

   // Reference model: predicts grant, checks outputs, pops on response handshake, pushes on accept.
   task automatic model_step();
      logic            free;
      int              g;
      int              j;
      logic [NREQ-1:0] exp_rdy;
      logic [WIDTH-1:0] d;
      exp_t            e;
      check("rsp_valid", rsp_valid, m_full);
      check("busy", busy, m_full);
      free = !m_full || rsp_ready;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
         j = (mptr + k) % NREQ;
         if (g < 0 && req_valid[j]) g = j;
      end
      exp_rdy = '0;
      if (g >= 0 && free) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      if (m_full && rsp_ready) begin
         check("sb_nonempty", sbq.size() != 0, 1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("sb_id", rsp_id, e.id);
            check("sb_data", rsp_data, e.dat);
            check("sb_ovf", rsp_ovf, e.ovf);
         end
      end
      if (exp_rdy != '0) begin
         d     = req_data[g*WIDTH +: WIDTH];
         e.id  = IDW'(g);
         e.dat = d + 16'd1;
         e.ovf = (d == 16'hFFFF);
         sbq.push_back(e);
         mptr   = (g + 1) % NREQ;
         m_full = 1'b1;
      end else if (m_full && rsp_ready) begin
         m_full = 1'b0;
      end
      last_acc = exp_rdy;
   endtask

   task automatic cycle();
      #1;
      model_step();
      @(negedge clk);
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int n = 0; n < 20 && (sbq.size() > 0 || m_full); n++) cycle();
      check("drain_empty", sbq.size(), 0);
   endtask

   initial begin
      logic [IDW-1:0] seq [6];
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b0;
      m_full    = 1'b0;
      mptr      = 0;
      last_acc  = '0;
      repeat (2) @(negedge clk);
      check("rst_valid", rsp_valid, 0);
      check("rst_data", rsp_data, 0);
      check("rst_id", rsp_id, 0);
      check("rst_ovf", rsp_ovf, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;

      // Reset while FULL: slot clears asynchronously, pointer returns to 0.
      req_valid = 4'b0010;
      set_data(1, 16'h1234);
      cycle();
      req_valid = '0;
      check("pre_rst_full", rsp_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", rsp_valid, 0);
      check("async_rst_data", rsp_data, 0);
      sbq.delete();
      m_full = 1'b0;
      mptr   = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // All valid, consumer always ready: round-robin with no bubbles, req0 first.
      for (int i = 0; i < NREQ; i++) set_data(i, 16'(16'h1000 * i + 16'h0010));
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         check("rr_valid", rsp_valid, 1);
         check("rr_seq", rsp_id, seq[k]);
      end

      // Backpressure with all valid: no grants, result held stable.
      rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         if (sbq.size() != 0) begin
            check("bp_data", rsp_data, sbq[0].dat);
            check("bp_id", rsp_id, sbq[0].id);
         end
      end
      rsp_ready = 1'b1;
      cycle();
      check("bp_release_id", rsp_id, 2);
      drain();

      // Single request from requester 2.
      req_valid = 4'b0100;
      set_data(2, 16'd41);
      cycle();
      req_valid = '0;
      check("single_data", rsp_data, 42);
      check("single_id", rsp_id, 2);
      check("single_ovf", rsp_ovf, 0);
      drain();

      // Wrap and just-below-wrap from requester 0.
      req_valid = 4'b0001;
      set_data(0, 16'hFFFF);
      cycle();
      check("wrap_data", rsp_data, 16'h0000);
      check("wrap_ovf", rsp_ovf, 1);
      set_data(0, 16'h7FFF);
      cycle();
      req_valid = '0;
      check("nowrap_data", rsp_data, 16'h8000);
      check("nowrap_ovf", rsp_ovf, 0);
      drain();

      // Random traffic honouring the hold-until-accepted rule.
      for (int c = 0; c < 1000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
               req_valid[i] = 1'b1;
               set_data(i, ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom));
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
         req_valid = req_valid & ~last_acc;
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
